hazard_ctrl: RTL and testbench

// - Stall/flush sequencer for the 5-stage MIPS pipeline; companion to the forwarding unit.
// - Detects hazards that forwarding cannot cover (load-use, branch/JR operands not yet available in ID).
// - Issues the per-stage write-enable and flush signals, squashes the wrong-path fetch on taken

---
 rtl/hazard_ctrl_pkg.sv | 54 +++++
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: JumpBranch codes, hazard FSM states and the
// per-state pipeline control decode used by the hazard sequencer.
package hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    JbOthers = 3'd0,
    JbBeq    = 3'd1,
    JbBne    = 3'd2,
    JbJr     = 3'd3,
    JbJ      = 3'd4,
    JbJal    = 3'd7
  } jump_branch_e;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StStall   = 2'd2,
    StMemWait = 2'd3
  } hazard_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam int unsigned StallW = 2;

  function automatic pipe_ctrl_t ctrl_for_state(hazard_state_e st);
    pipe_ctrl_t c;
    c = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
          id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_flush: 1'b0};
    case (st)
      StFlush: c.if_id_flush = 1'b1;
      StStall: begin
        c.pc_write    = 1'b0;
        c.if_id_write = 1'b0;
        c.id_ex_flush = 1'b1;
      end
      StMemWait: begin
        c.pc_write     = 1'b0;
        c.if_id_write  = 1'b0;
        c.ex_mem_write = 1'b0;
        c.mem_wb_flush = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use and branch-operand
// stalls, taken-branch fetch squash, data-memory freeze and performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ID_JumpBranch,
  input  logic [4:0]       ID_rsAddr,
  input  logic [4:0]       ID_rtAddr,
  input  logic             ID_UsesRt,
  input  logic             ID_MemWrite,
  input  logic             ID_Taken,
  input  logic [4:0]       EX_wrAddr,
  input  logic             EX_RegWrite,
  input  logic             EX_MemtoReg,
  input  logic [4:0]       MEM_wrAddr,
  input  logic             MEM_MemtoReg,
  input  logic             mem_busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(MEM_TIMEOUT - 1);

  jump_branch_e       jb;
  logic               ex_rs, ex_rt, mem_rs, mem_rt;
  logic               lu_rt, br_rt, is_br, lu;
  logic [StallW-1:0]  lu_len, br_len, stall_len;

  hazard_state_e      state_q, state_d, resume_q, resume_d;
  logic [StallW-1:0]  rem_q, rem_d;
  pipe_ctrl_t         ctrl_q;
  logic               mem_err_q;
  logic               flush_hit, stall_inc, timeout_hit;
  logic [TW-1:0]      busy_cnt;

  assign jb = jump_branch_e'(ID_JumpBranch);

  // Hazard detection: stall length is the worst case over all producers.
  always_comb begin
    ex_rs  = (EX_wrAddr != 5'd0) && (EX_wrAddr == ID_rsAddr);
    ex_rt  = (EX_wrAddr != 5'd0) && (EX_wrAddr == ID_rtAddr);
    mem_rs = (MEM_wrAddr != 5'd0) && (MEM_wrAddr == ID_rsAddr);
    mem_rt = (MEM_wrAddr != 5'd0) && (MEM_wrAddr == ID_rtAddr);
    // SW store data comes from WB->MEM forwarding, so rt of a store never stalls.
    lu_rt  = ID_UsesRt && !ID_MemWrite;
    br_rt  = (jb == JbBeq) || (jb == JbBne);
    is_br  = br_rt || (jb == JbJr);
    lu     = EX_MemtoReg && (ex_rs || (ex_rt && lu_rt));
    lu_len = lu ? 2'd1 : 2'd0;
    br_len = 2'd0;
    if (is_br) begin
      if (ex_rs || (br_rt && ex_rt)) begin
        if (EX_MemtoReg) begin
          br_len = 2'd2;
        end else if (EX_RegWrite) begin
          br_len = 2'd1;
        end
      end
      if ((br_len == 2'd0) && MEM_MemtoReg && (mem_rs || (br_rt && mem_rt))) begin
        br_len = 2'd1;
      end
    end
    stall_len = (br_len > lu_len) ? br_len : lu_len;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    resume_d  = resume_q;
    flush_hit = 1'b0;
    if (mem_busy) begin
      state_d = StMemWait;
      unique case (state_q)
        // The stall cycle just completed still counts; remember what is left.
        StStall: begin
          resume_d = (rem_q == 2'd1) ? StRun : StStall;
          rem_d    = rem_q - 2'd1;
        end
        StMemWait: resume_d = resume_q;
        StRun, StFlush: resume_d = StRun;
      endcase
    end else begin
      unique case (state_q)
        StMemWait: state_d = resume_q;
        StStall: begin
          if (rem_q == 2'd1) begin
            state_d = StRun;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
        StRun, StFlush: begin
          if (stall_len != 2'd0) begin
            state_d = StStall;
            rem_d   = stall_len;
          end else if (ID_Taken) begin
            state_d   = StFlush;
            flush_hit = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      endcase
    end
  end

  assign stall_inc   = (state_d == StStall) || (state_d == StMemWait);
  assign timeout_hit = mem_busy && (busy_cnt >= TimeoutLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      rem_q     <= '0;
      resume_q  <= StRun;
      ctrl_q    <= ctrl_for_state(StRun);
      mem_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      resume_q <= resume_d;
      ctrl_q   <= ctrl_for_state(state_d);
      if (timeout_hit) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (flush_hit),
    .count(flush_cnt)
  );

  sat_counter #(.CNT_W(TW)) u_busy_cnt (
    .clk  (clk),
    .clear(rst || !mem_busy),
    .inc  (mem_busy),
    .count(busy_cnt)
  );

  assign PC_Write     = ctrl_q.pc_write;
  assign IF_ID_Write  = ctrl_q.if_id_write;
  assign IF_ID_Flush  = ctrl_q.if_id_flush;
  assign ID_EX_Flush  = ctrl_q.id_ex_flush;
  assign EX_MEM_Write = ctrl_q.ex_mem_write;
  assign MEM_WB_Flush = ctrl_q.mem_wb_flush;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-kind reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned MEM_TIMEOUT = 64;
  localparam int          SAT         = (1 << CNT_W) - 1;

  localparam logic [2:0] JB_NONE = 3'd0, JB_BEQ = 3'd1, JB_BNE = 3'd2, JB_JR = 3'd3;
  localparam logic [2:0] JB_J = 3'd4, JB_JAL = 3'd7;

  // Kind of cycle the pipe is in, as seen on the control outputs.
  localparam int K_NORMAL = 0, K_FLUSH = 1, K_STALL = 2, K_FROZEN = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       ID_JumpBranch;
  logic [4:0]       ID_rsAddr, ID_rtAddr, EX_wrAddr, MEM_wrAddr;
  logic             ID_UsesRt, ID_MemWrite, ID_Taken;
  logic             EX_RegWrite, EX_MemtoReg, MEM_MemtoReg, mem_busy;
  logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic             EX_MEM_Write, MEM_WB_Flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  int kind, owed, busy_run, m_err, scnt, fcnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_JumpBranch(ID_JumpBranch),
    .ID_rsAddr    (ID_rsAddr),
    .ID_rtAddr    (ID_rtAddr),
    .ID_UsesRt    (ID_UsesRt),
    .ID_MemWrite  (ID_MemWrite),
    .ID_Taken     (ID_Taken),
    .EX_wrAddr    (EX_wrAddr),
    .EX_RegWrite  (EX_RegWrite),
    .EX_MemtoReg  (EX_MemtoReg),
    .MEM_wrAddr   (MEM_wrAddr),
    .MEM_MemtoReg (MEM_MemtoReg),
    .mem_busy     (mem_busy),
    .PC_Write     (PC_Write),
    .IF_ID_Write  (IF_ID_Write),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EX_Flush  (ID_EX_Flush),
    .EX_MEM_Write (EX_MEM_Write),
    .MEM_WB_Flush (MEM_WB_Flush),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_JumpBranch = JB_NONE; ID_rsAddr = 5'd0; ID_rtAddr = 5'd0;
    ID_UsesRt = 1'b0; ID_MemWrite = 1'b0; ID_Taken = 1'b0;
    EX_wrAddr = 5'd0; EX_RegWrite = 1'b0; EX_MemtoReg = 1'b0;
    MEM_wrAddr = 5'd0; MEM_MemtoReg = 1'b0;
  endtask

  task automatic set_id(input logic [2:0] jb, input int rs, input int rt, input bit uses_rt,
                        input bit sw, input bit taken);
    ID_JumpBranch = jb; ID_rsAddr = 5'(rs); ID_rtAddr = 5'(rt);
    ID_UsesRt = uses_rt; ID_MemWrite = sw; ID_Taken = taken;
  endtask

  task automatic set_ex(input int wr, input bit regwrite, input bit lw);
    EX_wrAddr = 5'(wr); EX_RegWrite = regwrite; EX_MemtoReg = lw;
  endtask

  function automatic bit reads(input logic [4:0] a, input bit use_rt);
    return (a != 5'd0) && ((a == ID_rsAddr) || (use_rt && (a == ID_rtAddr)));
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cycles the ID instruction must wait before its operands can be obtained.
  function automatic int hazard_len();
    int  need = 0;
    bit  br_rt = (ID_JumpBranch == JB_BEQ) || (ID_JumpBranch == JB_BNE);
    bit  is_br = br_rt || (ID_JumpBranch == JB_JR);
    if (EX_MemtoReg && reads(EX_wrAddr, ID_UsesRt && !ID_MemWrite)) need = 1;
    if (is_br) begin
      if (reads(EX_wrAddr, br_rt)) begin
        if (EX_MemtoReg) need = max2(need, 2);
        else if (EX_RegWrite) need = max2(need, 1);
      end
      if (MEM_MemtoReg && reads(MEM_wrAddr, br_rt)) need = max2(need, 1);
    end
    return need;
  endfunction

  // Advance the model with the inputs now applied, clock once, compare everything.
  task automatic tick(input string tag);
    int h;
    logic [5:0] exp_ctrl, obs_ctrl;
    h = hazard_len();
    if (rst) begin
      kind = K_NORMAL; owed = 0; busy_run = 0; m_err = 0; scnt = 0; fcnt = 0;
    end else begin
      busy_run = mem_busy ? busy_run + 1 : 0;
      if (busy_run >= MEM_TIMEOUT) m_err = 1;
      if (mem_busy) begin
        if (kind == K_STALL) owed--;
        kind = K_FROZEN;
      end else if (kind == K_FROZEN) begin
        kind = (owed > 0) ? K_STALL : K_NORMAL;
      end else if (kind == K_STALL) begin
        owed--;
        kind = (owed > 0) ? K_STALL : K_NORMAL;
      end else if (h > 0) begin
        kind = K_STALL; owed = h;
      end else if (ID_Taken) begin
        kind = K_FLUSH;
      end else begin
        kind = K_NORMAL;
      end
      if ((kind == K_STALL || kind == K_FROZEN) && scnt < SAT) scnt++;
      if (kind == K_FLUSH && fcnt < SAT) fcnt++;
    end
    @(posedge clk);
    #1;
    exp_ctrl = {kind == K_NORMAL || kind == K_FLUSH, kind == K_NORMAL || kind == K_FLUSH,
                kind == K_FLUSH, kind == K_STALL, kind != K_FROZEN, kind == K_FROZEN};
    obs_ctrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush};
    check({tag, "/ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl));
    check({tag, "/mem_err"}, 32'(mem_err), 32'(m_err));
    check({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(scnt));
    check({tag, "/flush_cnt"}, 32'(flush_cnt), 32'(fcnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(); mem_busy = 1'b0; rst = 1'b1;
    kind = K_NORMAL; owed = 0; busy_run = 0; m_err = 0; scnt = 0; fcnt = 0;
    tick("reset");
    tick("reset2");
    rst = 1'b0;
    tick("run_idle");

    // LW $1 in EX, ADD $2,$1,$3 in ID: one stall cycle.
    set_ex(1, 1, 1); set_id(JB_NONE, 1, 3, 1, 0, 0);
    tick("lu_detect");
    check("lu_pc_write", 32'(PC_Write), 32'd0);
    check("lu_id_ex_flush", 32'(ID_EX_Flush), 32'd1);
    idle();
    tick("lu_release");
    check("lu_run", 32'(PC_Write), 32'd1);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // LW $1 in EX, BEQ $1,$2 in ID: two stall cycles, then a taken flush.
    set_ex(1, 1, 1); set_id(JB_BEQ, 1, 2, 1, 0, 0);
    tick("beq_lw_s1");
    idle();
    tick("beq_lw_s2");
    check("beq_lw_s2_pc", 32'(PC_Write), 32'd0);
    tick("beq_lw_done");
    check("beq_lw_run", 32'(PC_Write), 32'd1);
    check("beq_lw_stall_cnt", 32'(stall_cnt), 32'd3);
    set_id(JB_BEQ, 1, 2, 1, 0, 1);
    tick("beq_taken");
    check("taken_if_id_flush", 32'(IF_ID_Flush), 32'd1);
    check("taken_pc_write", 32'(PC_Write), 32'd1);
    check("taken_flush_cnt", 32'(flush_cnt), 32'd1);
    idle();
    tick("taken_one_cycle");
    check("taken_cleared", 32'(IF_ID_Flush), 32'd0);

    // ADD $4 in EX, JR $4 in ID: one stall; with $0 as destination: none.
    set_ex(4, 1, 0); set_id(JB_JR, 4, 0, 0, 0, 0);
    tick("jr_alu");
    check("jr_alu_stall", 32'(PC_Write), 32'd0);
    idle();
    tick("jr_alu_release");
    set_ex(0, 1, 0); set_id(JB_JR, 0, 0, 0, 0, 0);
    tick("jr_r0");
    check("jr_r0_no_stall", 32'(PC_Write), 32'd1);
    // LW $5 in EX, SW $5 in ID: store data is forwarded, no stall.
    set_ex(5, 1, 1); set_id(JB_NONE, 6, 5, 1, 1, 0);
    tick("sw_data");
    check("sw_no_stall", 32'(PC_Write), 32'd1);
    // MEM LW feeding BNE: one stall; MEM ALU result: forwarded.
    idle(); MEM_wrAddr = 5'd7; MEM_MemtoReg = 1'b1; set_id(JB_BNE, 3, 7, 1, 0, 0);
    tick("bne_mem_lw");
    check("bne_mem_lw_stall", 32'(PC_Write), 32'd0);
    idle();
    tick("bne_mem_lw_release");
    MEM_wrAddr = 5'd7; set_id(JB_BNE, 3, 7, 1, 0, 0);
    tick("bne_mem_alu");
    check("bne_mem_alu_no_stall", 32'(PC_Write), 32'd1);

    // mem_busy for 3 cycles while in a 2-cycle stall.
    idle(); rst = 1'b1;
    tick("mb_reset");
    rst = 1'b0;
    set_ex(1, 1, 1); set_id(JB_BEQ, 1, 2, 1, 0, 0);
    tick("mb_detect");
    idle(); mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("mb_frozen");
      check("mb_mem_wb_flush", 32'(MEM_WB_Flush), 32'd1);
      check("mb_ex_mem_write", 32'(EX_MEM_Write), 32'd0);
    end
    mem_busy = 1'b0;
    tick("mb_resume");
    check("mb_resume_stall", 32'(ID_EX_Flush), 32'd1);
    tick("mb_done");
    check("mb_done_run", 32'(PC_Write), 32'd1);
    check("mb_stall_cnt", 32'(stall_cnt), 32'd5);

    // Timeout: mem_err rises on the 64th busy cycle and is sticky until reset.
    rst = 1'b1;
    tick("to_reset");
    rst = 1'b0; mem_busy = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick("to_busy");
    check("to_before", 32'(mem_err), 32'd0);
    tick("to_edge");
    check("to_rise", 32'(mem_err), 32'd1);
    check("to_stall_sat", 32'(stall_cnt), 32'(SAT));
    mem_busy = 1'b0;
    tick("to_drop1");
    tick("to_drop2");
    check("to_sticky", 32'(mem_err), 32'd1);
    rst = 1'b1;
    tick("to_clear");
    check("to_cleared", 32'(mem_err), 32'd0);
    rst = 1'b0;

    // Reset in the middle of a stall.
    set_ex(1, 1, 1); set_id(JB_BEQ, 1, 2, 1, 0, 0);
    tick("rs_detect");
    idle(); rst = 1'b1;
    tick("rs_reset");
    check("rs_pc_write", 32'(PC_Write), 32'd1);
    check("rs_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    tick("rs_run");

    // Random traffic on a small register window so matches are common.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 5))
        0: ID_JumpBranch = JB_NONE;
        1: ID_JumpBranch = JB_BEQ;
        2: ID_JumpBranch = JB_BNE;
        3: ID_JumpBranch = JB_JR;
        4: ID_JumpBranch = JB_J;
        default: ID_JumpBranch = JB_JAL;
      endcase
      ID_rsAddr    = 5'($urandom_range(0, 3));
      ID_rtAddr    = 5'($urandom_range(0, 3));
      ID_UsesRt    = 1'($urandom_range(0, 1));
      ID_MemWrite  = 1'($urandom_range(0, 1));
      ID_Taken     = 1'($urandom_range(0, 1));
      EX_wrAddr    = 5'($urandom_range(0, 3));
      EX_RegWrite  = 1'($urandom_range(0, 1));
      EX_MemtoReg  = 1'($urandom_range(0, 1));
      MEM_wrAddr   = 5'($urandom_range(0, 3));
      MEM_MemtoReg = 1'($urandom_range(0, 1));
      mem_busy     = ($urandom_range(0, 7) == 0);
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
